// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter: FSM encoding, clog2, stats width.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StBurst = 1'b1
   } arb_state_e;

   localparam int unsigned STAT_WIDTH = 32;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-one finder: returns the first set bit of req at or after ptr, wrapping at N.
module rr_pick #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!valid && req[(32'(ptr) + k) % N]) begin
            valid = 1'b1;
            idx   = W'((32'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing one registered FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester 32-bit accept counters on stat_words.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned BURST_LEN  = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dout_src,
   input  logic [NUM_REQ-1:0]            req_wr_en_src,
   output logic [NUM_REQ-1:0]            req_full_n,
   output logic [DATA_WIDTH-1:0]         din,
   output logic                          wr_en,
   input  logic                          full,
`ifdef FIFO_WR_ARB_STATS_EN
   output logic [NUM_REQ*STAT_WIDTH-1:0] stat_words,
`endif
   output logic [clog2(NUM_REQ)-1:0]     grant_id
);

   localparam int unsigned      IDX_W    = clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   arb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [7:0]            burst_cnt_q, burst_cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;

   logic                  win_valid;
   logic [IDX_W-1:0]      win_idx;
   logic [IDX_W-1:0]      win_next;
   logic [IDX_W-1:0]      owner_next;
   logic [IDX_W-1:0]      g;
   logic                  g_valid;
   logic                  load_ok;
   logic                  acc;

   rr_pick #(
      .N (NUM_REQ),
      .W (IDX_W)
   ) u_rr_pick (
      .req   (req_wr_en_src),
      .ptr   (rr_ptr_q),
      .valid (win_valid),
      .idx   (win_idx)
   );

   // Output stage may take a new word when empty or when its word drains this cycle.
   assign load_ok    = ~out_valid_q | ~full;
   assign win_next   = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
   assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      g           = owner_q;
      g_valid     = 1'b0;
      acc         = 1'b0;

      case (state_q)
         StIdle: begin
            g       = win_idx;
            g_valid = win_valid;
            if (win_valid && load_ok) begin
               acc         = 1'b1;
               burst_cnt_d = 8'd1;
               owner_d     = win_idx;
               if (BURST_LEN > 1) begin
                  state_d = StBurst;
               end else begin
                  rr_ptr_d = win_next;
               end
            end
         end
         StBurst: begin
            g_valid = 1'b1;
            // A stall holds everything; an owner that goes quiet costs one bubble.
            if (load_ok) begin
               if (req_wr_en_src[owner_q]) begin
                  acc         = 1'b1;
                  burst_cnt_d = burst_cnt_q + 8'd1;
                  if (9'(burst_cnt_q) + 9'd1 == 9'(BURST_LEN)) begin
                     state_d  = StIdle;
                     rr_ptr_d = owner_next;
                  end
               end else begin
                  state_d  = StIdle;
                  rr_ptr_d = owner_next;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      din_d       = din_q;
      req_full_n  = '0;
      if (acc) begin
         din_d       = req_dout_src[g*DATA_WIDTH +: DATA_WIDTH];
         out_valid_d = 1'b1;
      end else if (load_ok) begin
         out_valid_d = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         req_full_n[i] = load_ok & g_valid & (IDX_W'(i) == g);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         out_valid_q <= 1'b0;
         din_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         out_valid_q <= out_valid_d;
         din_q       <= din_d;
      end
   end

   assign din      = din_q;
   assign wr_en    = out_valid_q;
   assign grant_id = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reset) begin
            stat_q[i] <= '0;
         end else if (acc && (g == IDX_W'(i))) begin
            stat_q[i] <= stat_q[i] + STAT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      stat_words = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_words[i*STAT_WIDTH +: STAT_WIDTH] = stat_q[i];
      end
   end
`endif

endmodule
